alu_ctrl_stage: RTL and testbench

//  Pipelined, parametrised ALU control stage for the LEGv8 datapath. Decodes ALUop

---
 rtl/alu_ctrl_stage.sv | 151 +++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// LEGv8 ALU control stage: decodes ALUop/Opcode into a registered ALUCtrl. Single-cycle ops have latency 1 and MUL has latency MUL_CYCLES; in_ready drops while the output is stalled, a MUL runs, or flush is high.
// MUL sequencing is present only when ALU_CTRL_MUL_EN is defined. Otherwise MUL decodes as illegal.
module alu_ctrl_stage #(
    parameter int OPC_W      = 11,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUop,
    input  logic [OPC_W-1:0]  Opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUCtrl,
    output logic              illegal,
    output logic              mc_busy
);

`ifdef ALU_CTRL_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_MULTI = 1'b1;

    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(11'b10001011000);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(11'b11001011000);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(11'b10001010000);
    localparam logic [OPC_W-1:0] OP_ORR = OPC_W'(11'b10101010000);
    localparam logic [OPC_W-1:0] OP_EOR = OPC_W'(11'b11001010000);
    localparam logic [OPC_W-1:0] OP_LSL = OPC_W'(11'b11010011011);
    localparam logic [OPC_W-1:0] OP_LSR = OPC_W'(11'b11010011010);
    localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(11'b10011011000);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;

    logic [3:0] dec_ctrl;
    logic       dec_ill;
    logic       dec_mul;
    logic       accept;

    always_comb begin
        dec_ctrl = 4'b1111;
        dec_ill  = 1'b1;
        dec_mul  = 1'b0;
        case (ALUop)
            2'b00: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
            2'b01: begin dec_ctrl = 4'b0111; dec_ill = 1'b0; end
            2'b10: begin
                case (Opcode)
                    OP_ADD: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
                    OP_SUB: begin dec_ctrl = 4'b0110; dec_ill = 1'b0; end
                    OP_AND: begin dec_ctrl = 4'b0000; dec_ill = 1'b0; end
                    OP_ORR: begin dec_ctrl = 4'b0001; dec_ill = 1'b0; end
                    OP_EOR: begin dec_ctrl = 4'b0011; dec_ill = 1'b0; end
                    OP_LSL: begin dec_ctrl = 4'b0100; dec_ill = 1'b0; end
                    OP_LSR: begin dec_ctrl = 4'b0101; dec_ill = 1'b0; end
                    OP_MUL: begin
                        if (MUL_EN) begin
                            dec_ctrl = 4'b1000;
                            dec_ill  = 1'b0;
                            dec_mul  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: begin
                // I-type opcodes are 10 bits wide; the low bit belongs to the immediate
                case (Opcode[OPC_W-1 -: 10])
                    10'b1001000100: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
                    10'b1101000100: begin dec_ctrl = 4'b0110; dec_ill = 1'b0; end
                    10'b1001001000: begin dec_ctrl = 4'b0000; dec_ill = 1'b0; end
                    10'b1011001000: begin dec_ctrl = 4'b0001; dec_ill = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

    assign in_ready = (state_q == S_IDLE) & (~out_valid_q | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        illegal_d   = illegal_q;
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (state_q == S_MULTI) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (accept) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_ill;
            if (dec_mul) begin
                // Output stays invalid until the count runs out
                state_d     = S_MULTI;
                cnt_d       = CNT_W'(MUL_CYCLES - 1);
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= 4'b0000;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALUCtrl   = CTRL_W'(ctrl_q);
    assign illegal   = illegal_q;
    assign mc_busy   = MUL_EN & (state_q == S_MULTI);

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: vector table, directed handshake/MUL/flush/reset sequences, random run vs reference model.
module tb_alu_ctrl_stage;
    localparam int OPC_W      = 11;
    localparam int CTRL_W     = 6;
    localparam int MUL_CYCLES = 4;

`ifdef ALU_CTRL_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              resetl;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ALUop;
    logic [OPC_W-1:0]  Opcode;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ALUCtrl;
    logic              illegal;
    logic              mc_busy;

    alu_ctrl_stage #(.OPC_W(OPC_W), .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .CLK(CLK), .resetl(resetl), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .Opcode(Opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUCtrl(ALUCtrl), .illegal(illegal), .mc_busy(mc_busy)
    );

    always #5 CLK = ~CLK;

    localparam logic [10:0] R_OPC [7] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
        11'b10101010000, 11'b11001010000, 11'b11010011011, 11'b11010011010};
    localparam logic [3:0]  R_CTL [7] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5};
    localparam logic [9:0]  I_OPC [4] = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    localparam logic [3:0]  I_CTL [4] = '{4'd2, 4'd6, 4'd0, 4'd1};
    localparam logic [10:0] MUL_OPC = 11'b10011011000;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [10:0] opc,
                                       output logic [3:0] c, output logic ill, output logic mul);
        c = 4'hF; ill = 1'b1; mul = 1'b0;
        if (op == 2'b00) begin c = 4'd2; ill = 1'b0; end
        else if (op == 2'b01) begin c = 4'd7; ill = 1'b0; end
        else if (op == 2'b10) begin
            for (int k = 0; k < 7; k++)
                if (opc == R_OPC[k]) begin c = R_CTL[k]; ill = 1'b0; end
            if (opc == MUL_OPC && MUL_ON) begin c = 4'd8; ill = 1'b0; mul = 1'b1; end
        end else begin
            for (int k = 0; k < 4; k++)
                if (opc[10:1] == I_OPC[k]) begin c = I_CTL[k]; ill = 1'b0; end
        end
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [10:0] opc;
        logic [3:0]  ctl;
        logic        ill;
    } vec_t;

    vec_t vt [16];

    // reference model state
    logic       m_valid, m_ill, m_rdy, d_ill, d_mul;
    logic [3:0] m_ctrl, d_ctrl;
    int         m_wait;

    initial begin
        vt[0]  = '{2'b00, 11'b00000000000, 4'b0010, 1'b0};
        vt[1]  = '{2'b01, 11'b11111111111, 4'b0111, 1'b0};
        vt[2]  = '{2'b10, 11'b10001011000, 4'b0010, 1'b0};
        vt[3]  = '{2'b10, 11'b11001011000, 4'b0110, 1'b0};
        vt[4]  = '{2'b10, 11'b10001010000, 4'b0000, 1'b0};
        vt[5]  = '{2'b10, 11'b10101010000, 4'b0001, 1'b0};
        vt[6]  = '{2'b10, 11'b11001010000, 4'b0011, 1'b0};
        vt[7]  = '{2'b10, 11'b11010011011, 4'b0100, 1'b0};
        vt[8]  = '{2'b10, 11'b11010011010, 4'b0101, 1'b0};
        vt[9]  = '{2'b10, 11'b11111111111, 4'b1111, 1'b1};
        vt[10] = '{2'b10, 11'b10001011001, 4'b1111, 1'b1};
        vt[11] = '{2'b11, 11'b10010001000, 4'b0010, 1'b0};
        vt[12] = '{2'b11, 11'b11010001001, 4'b0110, 1'b0};
        vt[13] = '{2'b11, 11'b10010010000, 4'b0000, 1'b0};
        vt[14] = '{2'b11, 11'b10110010001, 4'b0001, 1'b0};
        vt[15] = '{2'b11, 11'b00000000000, 4'b1111, 1'b1};

        resetl = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUop = 2'b00; Opcode = '0;
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset ALUCtrl", 32'(ALUCtrl), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset mc_busy", 32'(mc_busy), 32'd0);
        resetl = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 16; i++) begin
            ALUop = vt[i].op; Opcode = vt[i].opc; in_valid = 1'b1; out_ready = 1'b1;
            #1 chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d ALUCtrl", i), 32'(ALUCtrl), 32'(vt[i].ctl));
            chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vt[i].ill));
            in_valid = 1'b0;
            tick();
            chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back stream at full throughput
        for (int i = 0; i < 4; i++) begin
            ALUop = 2'b10; Opcode = vt[2 + i].opc; in_valid = 1'b1; out_ready = 1'b1;
            #1 chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d ALUCtrl", i), 32'(ALUCtrl), 32'(vt[2 + i].ctl));
        end
        in_valid = 1'b0;
        tick();

        // Output stall holds data and blocks input
        ALUop = 2'b10; Opcode = 11'b11001011000; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        Opcode = 11'b10001011000; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d ALUCtrl", i), 32'(ALUCtrl), 32'd6);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("stall release in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("stall consumed", 32'(out_valid), 32'd0);

        // MUL
        ALUop = 2'b10; Opcode = MUL_OPC; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ALU_CTRL_MUL_EN
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mul%0d mc_busy", i), 32'(mc_busy), 32'd1);
            chk($sformatf("mul%0d out_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("mul%0d in_ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        chk("mul done out_valid", 32'(out_valid), 32'd1);
        chk("mul done ALUCtrl", 32'(ALUCtrl), 32'd8);
        chk("mul done illegal", 32'(illegal), 32'd0);
        chk("mul done mc_busy", 32'(mc_busy), 32'd0);
`else
        chk("mul off out_valid", 32'(out_valid), 32'd1);
        chk("mul off ALUCtrl", 32'(ALUCtrl), 32'hF);
        chk("mul off illegal", 32'(illegal), 32'd1);
        chk("mul off mc_busy", 32'(mc_busy), 32'd0);
`endif
        tick();

        // Flush drops the pending output and a same-cycle request
        ALUop = 2'b10; Opcode = 11'b11111111111; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        Opcode = 11'b10001011000; flush = 1'b1;
        #1 chk("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush illegal", 32'(illegal), 32'd0);
        chk("flush in_ready after", 32'(in_ready), 32'd1);
        tick();
        chk("flush no late output", 32'(out_valid), 32'd0);
`ifdef ALU_CTRL_MUL_EN
        Opcode = MUL_OPC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        Opcode = 11'b10001011000; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("mflush out_valid", 32'(out_valid), 32'd0);
        chk("mflush mc_busy", 32'(mc_busy), 32'd0);
        chk("mflush in_ready", 32'(in_ready), 32'd1);
        repeat (4) tick();
        chk("mflush no output", 32'(out_valid), 32'd0);
`endif

        // Asynchronous reset mid-operation
        ALUop = 2'b10; Opcode = MUL_OPC; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2 resetl = 1'b0;
        #1 chk("areset out_valid", 32'(out_valid), 32'd0);
        chk("areset ALUCtrl", 32'(ALUCtrl), 32'd0);
        chk("areset illegal", 32'(illegal), 32'd0);
        chk("areset mc_busy", 32'(mc_busy), 32'd0);
        tick();
        resetl = 1'b1; out_ready = 1'b1;
        repeat (5) tick();
        chk("areset no output", 32'(out_valid), 32'd0);

        // Random traffic against the reference model
        m_valid = 1'b0; m_ill = 1'b0; m_ctrl = 4'd0; m_wait = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            ALUop     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: Opcode = R_OPC[$urandom_range(0, 6)];
                7:       Opcode = MUL_OPC;
                8:       Opcode = {I_OPC[$urandom_range(0, 3)], 1'($urandom_range(0, 1))};
                default: Opcode = 11'($urandom);
            endcase
            m_rdy = (m_wait == 0) && (!m_valid || out_ready) && !flush;
            #1;
            chk("rand in_ready", 32'(in_ready), 32'(m_rdy));
            chk("rand out_valid", 32'(out_valid), 32'(m_valid));
            chk("rand mc_busy", 32'(mc_busy), 32'(m_wait > 0));
            if (m_valid) begin
                chk("rand ALUCtrl", 32'(ALUCtrl), 32'(m_ctrl));
                chk("rand illegal", 32'(illegal), 32'(m_ill));
            end
            if (flush) begin
                m_valid = 1'b0; m_ill = 1'b0; m_wait = 0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end else if (in_valid && m_rdy) begin
                ref_decode(ALUop, Opcode, d_ctrl, d_ill, d_mul);
                m_ctrl = d_ctrl;
                m_ill  = d_ill;
                if (d_mul) begin
                    m_valid = 1'b0;
                    m_wait  = MUL_CYCLES - 1;
                end else begin
                    m_valid = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
